btn_event_sched: RTL and testbench
==================================

BTN_EVENT_SCHED -- requirements
Module: btn_event_sched

Interface
REQ-001 Parameter: DEPTH, 4, event FIFO depth (power of two, >=2).
REQ-002 Parameter: DROP_W, 8, width of dropped-event counter.
REQ-003 Port: clk  in  1  single system clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: sw_code  in  3  button code from the switch interface: 0 none, 1..4 button, 5..7 illegal.
REQ-006 Port: sw_rst_n  in  1  debounced soft-reset from the switch interface, active low.
REQ-007 Port: evt_ready  in  1  game logic accepts the presented event.
REQ-008 Port: evt_valid  out  1  an event is presented on evt_code.
REQ-009 Port: evt_code  out  3  presented button code, 1..4.
REQ-010 Port: evt_count  out  $clog2(DEPTH)+1  events currently queued.
REQ-011 Port: drop_cnt  out  DROP_W  events lost to a full queue, saturating.
REQ-012 Port: game_rst  out  1  one-cycle soft-reset pulse to game logic.

Function
REQ-013 The block SHALL register sw_code and sw_rst_n each cycle as code_q and srst_q.
REQ-014 A new event SHALL be detected when sw_code is in 1..4 and sw_code != code_q; a held code SHALL yield exactly one event.
REQ-015 Codes 5..7 SHALL be ignored and SHALL NOT update drop_cnt.
REQ-016 A detected event SHALL be pushed that cycle; evt_valid SHALL rise no earlier than the next cycle (first-word latency 1).
REQ-017 Pop occurs when evt_valid and evt_ready; evt_code SHALL stay stable while evt_valid and not evt_ready.
REQ-018 Events SHALL be delivered in arrival order; evt_count SHALL equal pushes minus pops minus flushed entries.
REQ-019 Push when full without pop: event discarded, drop_cnt increments, saturates at all-ones.
REQ-020 Push and pop in the same cycle while full: push accepted, evt_count unchanged, no drop.
REQ-021 Pop and no push when evt_count=1: evt_valid deasserts the next cycle.
REQ-022 FSM states: EMPTY, ACTIVE, FLUSH.
REQ-023 EMPTY->ACTIVE on push; ACTIVE->EMPTY when the queue becomes empty; otherwise hold.
REQ-024 Falling edge of sw_rst_n (srst_q=1, sw_rst_n=0) SHALL enter FLUSH from any state, overriding any push that cycle.
REQ-025 In FLUSH: queue emptied, evt_valid=0, game_rst=1, detected events discarded without counting; FLUSH->EMPTY after exactly one cycle.
REQ-026 game_rst SHALL be high only in FLUSH; sw_rst_n held low SHALL give a single pulse.
REQ-027 drop_cnt SHALL be cleared only by rst, not by FLUSH.

Reset
REQ-028 When rst is high at a clock edge: state=EMPTY, queue empty, evt_valid=0, evt_code=0, evt_count=0, drop_cnt=0, game_rst=0, code_q=0, srst_q=1.
REQ-029 rst SHALL take priority over every other event, including a flush or push in the same cycle.

Structure
REQ-030 Shared package btn_evt_pkg SHALL hold code constants BTN_NONE=0, BTN1..BTN4=1..4, and the FSM state type.
REQ-031 The queue SHALL be a sub-module evt_fifo (synchronous FIFO with push/pop/full/empty/count); detection, FSM and counters stay in btn_event_sched.

Verification
REQ-032 sw_code 0->2 held 10 cycles, evt_ready=1 -> exactly one event, evt_code=2, evt_valid high one cycle.
REQ-033 Codes 1,0,1,0,3 with evt_ready=0 -> evt_count=3, then with ready delivers 1,1,3 in order.
REQ-034 evt_ready=0, 6 distinct events into DEPTH=4 -> evt_count=4, drop_cnt=2; then 300 more drops -> drop_cnt=255.
REQ-035 Queue full, new event with evt_ready=1 same cycle -> no drop, evt_count stays 4.
REQ-036 Queue holding 3, sw_rst_n 1->0 with simultaneous event -> one-cycle game_rst, evt_count=0, evt_valid=0, drop_cnt unchanged.
REQ-037 rst asserted mid-stream with a push and flush pending -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared button codes and scheduler FSM state type.
package btn_evt_pkg;

  localparam logic [2:0] BTN_NONE = 3'd0;
  localparam logic [2:0] BTN1     = 3'd1;
  localparam logic [2:0] BTN2     = 3'd2;
  localparam logic [2:0] BTN3     = 3'd3;
  localparam logic [2:0] BTN4     = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  function automatic logic is_button(input logic [2:0] code);
    return (code >= BTN1) && (code <= BTN4);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO for button events.
// A push while full is accepted only if a pop happens in the same cycle.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_sched.sv
// Turns switch-interface button codes into a queued event stream with
// overflow counting and a soft-reset flush that pulses game_rst.
module btn_event_sched
  import btn_evt_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             sw_code,
  input  logic                   sw_rst_n,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [2:0]             evt_code,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   game_rst,
  output logic [1:0]             fsm_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  state_t        state_d;
  logic [2:0]    code_q;
  logic          srst_q;
  logic          detect;
  logic          flush_req;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          drop_ev;
  logic [2:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  // Handshake: an event transfers on a cycle where evt_valid && evt_ready;
  // while evt_valid is high and evt_ready low, evt_code holds its value.

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= BTN_NONE;
      srst_q <= 1'b1;
    end else begin
      code_q <= sw_code;
      srst_q <= sw_rst_n;
    end
  end

  assign detect    = is_button(sw_code) && (sw_code != code_q);
  assign flush_req = srst_q && !sw_rst_n;
  assign pop       = evt_valid && evt_ready;
  // Events seen while flushing or entering a flush are discarded uncounted.
  assign push_req  = detect && !flush_req && (state != ST_FLUSH);
  assign push      = push_req && (!full || pop);
  assign drop_ev   = push_req && full && !pop;

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (3)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_req),
    .push    (push),
    .pop     (pop),
    .wr_data (sw_code),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (flush_req) begin
      state_d = ST_FLUSH;
    end else begin
      case (state)
        ST_EMPTY:  if (push) state_d = ST_ACTIVE;
        ST_ACTIVE: if (pop && !push && (count == CW'(1))) state_d = ST_EMPTY;
        ST_FLUSH:  state_d = ST_EMPTY;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    evt_valid = (state == ST_ACTIVE) && !empty;
    game_rst  = (state == ST_FLUSH);
    evt_code  = evt_valid ? head : BTN_NONE;
    evt_count = count;
    fsm_state = state;
  end

  // Saturating; only the hard reset clears it, a flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_ev && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// Self-checking bench for btn_event_sched: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_btn_event_sched;
  import btn_evt_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw_code;
  logic       sw_rst_n;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] evt_count;
  logic [7:0] drop_cnt;
  logic       game_rst;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  btn_event_sched #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_code   (sw_code),
    .sw_rst_n  (sw_rst_n),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .drop_cnt  (drop_cnt),
    .game_rst  (game_rst),
    .fsm_state (fsm_state)
  );

  // Reference model: queue of pending codes plus the few flags the rules need.
  logic [2:0] exp_q[$];
  int         m_drop;
  logic [2:0] m_prev_code;
  logic       m_prev_srst;
  logic       m_flush;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  code;
    logic        rstn;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [15:0] pack(input logic v, input logic [2:0] c,
                                       input int n, input int d, input logic g);
    return {v, c, 3'(n), 8'(d), g};
  endfunction

  function automatic logic [15:0] dut_out();
    return {evt_valid, evt_code, evt_count, drop_cnt, game_rst};
  endfunction

  function automatic logic [15:0] model_out();
    logic v;
    v = (exp_q.size() > 0) && !m_flush;
    return pack(v, v ? exp_q[0] : 3'd0, exp_q.size(), m_drop, m_flush);
  endfunction

  task automatic model_step(input logic r, input logic [2:0] c, input logic n, input logic rdy);
    logic vnow, det, fall;
    if (r) begin
      exp_q.delete();
      m_drop = 0;
      m_prev_code = 3'd0;
      m_prev_srst = 1'b1;
      m_flush = 1'b0;
    end else begin
      vnow = (exp_q.size() > 0) && !m_flush;
      det  = (c >= 3'd1) && (c <= 3'd4) && (c != m_prev_code);
      fall = m_prev_srst && !n;
      if (fall) begin
        exp_q.delete();
        m_flush = 1'b1;
      end else if (m_flush) begin
        m_flush = 1'b0;
      end else begin
        if (vnow && rdy) void'(exp_q.pop_front());
        if (det) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(c);
          else if (m_drop < 255) m_drop++;
        end
      end
      m_prev_code = c;
      m_prev_srst = n;
    end
  endtask

  task automatic apply(input logic r, input logic [2:0] c, input logic n, input logic rdy);
    rst = r;
    sw_code = c;
    sw_rst_n = n;
    evt_ready = rdy;
    @(posedge clk);
    model_step(r, c, n, rdy);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%0d code=%0d cnt=%0d drop=%0d grst=%0d, expected v=%0d code=%0d cnt=%0d drop=%0d grst=%0d",
               name, act[15], act[14:12], act[11:9], act[8:1], act[0],
               exp[15], exp[14:12], exp[11:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic check_state(input string name, input state_t exp);
    n_vec++;
    if (fsm_state !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d, expected %0d", name, fsm_state, exp);
    end
  endtask

  task automatic do_reset();
    apply(1'b1, 3'd0, 1'b1, 1'b0);
    apply(1'b1, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    // Held code 2 gives one event; then 1,0,1,0,3 queue and drain in order.
    tbl[0]  = '{3'd2, 1'b1, 1'b1, pack(1, 2, 1, 0, 0)};
    tbl[1]  = '{3'd2, 1'b1, 1'b1, pack(0, 0, 0, 0, 0)};
    tbl[2]  = '{3'd2, 1'b1, 1'b1, pack(0, 0, 0, 0, 0)};
    tbl[3]  = '{3'd2, 1'b1, 1'b1, pack(0, 0, 0, 0, 0)};
    tbl[4]  = '{3'd2, 1'b1, 1'b1, pack(0, 0, 0, 0, 0)};
    tbl[5]  = '{3'd2, 1'b1, 1'b1, pack(0, 0, 0, 0, 0)};
    tbl[6]  = '{3'd1, 1'b1, 1'b0, pack(1, 1, 1, 0, 0)};
    tbl[7]  = '{3'd0, 1'b1, 1'b0, pack(1, 1, 1, 0, 0)};
    tbl[8]  = '{3'd1, 1'b1, 1'b0, pack(1, 1, 2, 0, 0)};
    tbl[9]  = '{3'd0, 1'b1, 1'b0, pack(1, 1, 2, 0, 0)};
    tbl[10] = '{3'd3, 1'b1, 1'b0, pack(1, 1, 3, 0, 0)};
    tbl[11] = '{3'd3, 1'b1, 1'b1, pack(1, 1, 2, 0, 0)};
    tbl[12] = '{3'd0, 1'b1, 1'b1, pack(1, 3, 1, 0, 0)};
    tbl[13] = '{3'd0, 1'b1, 1'b1, pack(0, 0, 0, 0, 0)};

    do_reset();
    check("reset_outputs", dut_out(), 16'h0000);
    check_state("reset_state", ST_EMPTY);

    for (int i = 0; i < 14; i++) begin
      apply(1'b0, tbl[i].code, tbl[i].rstn, tbl[i].rdy);
      check($sformatf("table_%0d", i), dut_out(), tbl[i].exp);
    end

    // Full queue with a simultaneous pop and push: accepted, no drop.
    do_reset();
    apply(1'b0, 3'd1, 1'b1, 1'b0);
    apply(1'b0, 3'd2, 1'b1, 1'b0);
    apply(1'b0, 3'd3, 1'b1, 1'b0);
    apply(1'b0, 3'd4, 1'b1, 1'b0);
    check("full_fill", dut_out(), pack(1, 1, 4, 0, 0));
    apply(1'b0, 3'd1, 1'b1, 1'b1);
    check("full_push_pop", dut_out(), pack(1, 2, 4, 0, 0));
    check("full_push_pop_model", dut_out(), model_out());

    // Flush with an event in the same cycle; drop_cnt survives.
    do_reset();
    apply(1'b0, 3'd1, 1'b1, 1'b0);
    apply(1'b0, 3'd2, 1'b1, 1'b0);
    apply(1'b0, 3'd3, 1'b1, 1'b0);
    apply(1'b0, 3'd4, 1'b1, 1'b0);
    apply(1'b0, 3'd1, 1'b1, 1'b0);
    check("one_drop", dut_out(), pack(1, 1, 4, 1, 0));
    apply(1'b0, 3'd0, 1'b1, 1'b1);
    check("hold_three", dut_out(), pack(1, 2, 3, 1, 0));
    apply(1'b0, 3'd2, 1'b0, 1'b0);
    check("flush_pulse", dut_out(), pack(0, 0, 0, 1, 1));
    check_state("flush_state", ST_FLUSH);
    apply(1'b0, 3'd2, 1'b0, 1'b0);
    check("flush_end", dut_out(), pack(0, 0, 0, 1, 0));
    apply(1'b0, 3'd2, 1'b0, 1'b0);
    check("flush_held_low", dut_out(), pack(0, 0, 0, 1, 0));
    apply(1'b0, 3'd0, 1'b1, 1'b0);
    check("flush_release", dut_out(), model_out());

    // Overflow and saturation of drop_cnt.
    do_reset();
    for (int i = 0; i < 6; i++) apply(1'b0, 3'((i % 4) + 1), 1'b1, 1'b0);
    check("overflow_two", dut_out(), pack(1, 1, 4, 2, 0));
    for (int i = 0; i < 300; i++) apply(1'b0, (i % 2 == 0) ? 3'd3 : 3'd4, 1'b1, 1'b0);
    check("drop_saturate", dut_out(), pack(1, 1, 4, 255, 0));

    // Hard reset wins over a pending flush and push.
    apply(1'b1, 3'd1, 1'b0, 1'b1);
    check("rst_priority", dut_out(), 16'h0000);
    check_state("rst_priority_state", ST_EMPTY);
    apply(1'b0, 3'd1, 1'b1, 1'b0);
    check("post_rst_event", dut_out(), pack(1, 1, 1, 0, 0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic r, n, rdy;
      int rdy_pct;
      rdy_pct = ((i / 250) % 3 == 0) ? 20 : (((i / 250) % 3 == 1) ? 50 : 90);
      r   = ($urandom_range(0, 199) == 0);
      n   = ($urandom_range(0, 29) != 0);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      apply(r, 3'($urandom_range(0, 7)), n, rdy);
      check($sformatf("random_%0d", i), dut_out(), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
